// File: rtl/tx_sched_pkg.sv
// Shared types for the transmit priority scheduler: ID width, FSM encoding
// and the per-slot record.
package tx_sched_pkg;
  localparam int ID_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_REQ    = 2'd2,
    ST_ACTIVE = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            pend;
  } slot_t;
endpackage

// File: rtl/tx_prio_sel.sv
// Combinational winner finder: lowest ID among pending slots, lowest index
// on equal IDs.
module tx_prio_sel
  import tx_sched_pkg::*;
#(
  parameter int NBUF = 4,
  parameter int IDXW = 2
) (
  input  logic [NBUF-1:0]      pend_i,
  input  logic [NBUF*ID_W-1:0] ids_i,
  output logic                 win_vld,
  output logic [IDXW-1:0]      win_idx,
  output logic [ID_W-1:0]      win_id
);
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_id  = '0;
    // Strict less-than keeps the earlier (lower) index on ties.
    for (int i = 0; i < NBUF; i++) begin
      if (pend_i[i] && (!win_vld || (ids_i[i*ID_W +: ID_W] < win_id))) begin
        win_vld = 1'b1;
        win_idx = IDXW'(i);
        win_id  = ids_i[i*ID_W +: ID_W];
      end
    end
  end
endmodule

// File: rtl/tx_prio_sched.sv
// Transmit scheduler: holds NBUF pending frames, offers the lowest ID to the
// bit-stream transmitter and tracks it to success, retry, loss or abort.
module tx_prio_sched
  import tx_sched_pkg::*;
#(
  parameter int NBUF      = 4,
  parameter int IDXW      = 2,
  parameter int RETRY_MAX = 16,
  parameter int RCW       = 5
) (
  input  logic            clk,
  input  logic            g_rst,
  input  logic            ld_en,
  input  logic [IDXW-1:0] ld_idx,
  input  logic [ID_W-1:0] ld_id,
  input  logic [NBUF-1:0] abort_req,
  input  logic            bus_idle,
  input  logic            sof_sent,
  input  logic            arbtr_lost,
  input  logic            tx_lst_bit_eof,
  input  logic            tx_err_pre,
  output logic            tx_req,
  output logic [ID_W-1:0] tx_prio_id,
  output logic [IDXW-1:0] tx_idx,
  output logic [NBUF-1:0] pend,
  output logic [NBUF-1:0] tx_done,
  output logic [NBUF-1:0] tx_fail
);
  tx_state_e             state_q;
  slot_t     [NBUF-1:0]  slot_q;
  logic      [IDXW-1:0]  tx_idx_q;
  logic      [ID_W-1:0]  tx_id_q;
  logic                  tx_req_q;
  logic      [NBUF-1:0]  done_q, fail_q;
  logic      [RCW-1:0]   retry_q, retry_inc;
  logic                  abort_pnd_q;

  logic [NBUF-1:0]      pend_vec;
  logic [NBUF*ID_W-1:0] id_vec;
  logic                 win_vld, pre_vld;
  logic [IDXW-1:0]      win_idx;
  logic [0:0]           pre_idx;
  logic [ID_W-1:0]      win_id, pre_id;

  always_comb begin
    pend_vec = '0;
    id_vec   = '0;
    for (int i = 0; i < NBUF; i++) begin
      pend_vec[i]               = slot_q[i].pend;
      id_vec[i*ID_W +: ID_W]    = slot_q[i].id;
    end
  end

  tx_prio_sel #(.NBUF(NBUF), .IDXW(IDXW)) u_sel (
    .pend_i (pend_vec),
    .ids_i  (id_vec),
    .win_vld(win_vld),
    .win_idx(win_idx),
    .win_id (win_id)
  );

  // Two-entry compare: index 0 is the requested frame, index 1 the incoming load.
  tx_prio_sel #(.NBUF(2), .IDXW(1)) u_pre (
    .pend_i ({ld_en, 1'b1}),
    .ids_i  ({ld_id, tx_id_q}),
    .win_vld(pre_vld),
    .win_idx(pre_idx),
    .win_id (pre_id)
  );

  logic            locked, ld_lower, preempt, abort_hit, lim_hit;
  logic            fin_ok, fin_err, fin_lost, fin_fail;
  logic [NBUF-1:0] act_sel, ld_hit, abort_clr;

  always_comb begin
    // The slot counts as on the wire from the sof_sent cycle onwards.
    locked = (state_q == ST_ACTIVE) || ((state_q == ST_REQ) && sof_sent);
    for (int i = 0; i < NBUF; i++) begin
      act_sel[i]   = locked && (tx_idx_q == IDXW'(i));
      ld_hit[i]    = ld_en && (ld_idx == IDXW'(i)) && !act_sel[i];
      abort_clr[i] = abort_req[i] && slot_q[i].pend && !ld_hit[i] && !act_sel[i];
    end
    ld_lower  = pre_vld && pre_idx[0] && (pre_id < tx_id_q);
    preempt   = ld_lower || ld_hit[tx_idx_q] || abort_req[tx_idx_q] ||
                !win_vld || (win_idx != tx_idx_q);
    abort_hit = abort_pnd_q || abort_req[tx_idx_q];
    retry_inc = retry_q + RCW'(1);
    lim_hit   = (RETRY_MAX != 0) && (retry_inc == RCW'(RETRY_MAX));
    fin_ok    = (state_q == ST_ACTIVE) && tx_lst_bit_eof && !tx_err_pre;
    fin_err   = (state_q == ST_ACTIVE) && tx_err_pre;
    fin_lost  = (state_q == ST_ACTIVE) && arbtr_lost && !tx_lst_bit_eof && !tx_err_pre;
    fin_fail  = (fin_err && (lim_hit || abort_hit)) || (fin_lost && abort_hit);
  end

  // Handshake: tx_req stays high until sof_sent is seen in REQ; the frame is
  // then owned by the transmitter until eof, error or arbitration loss.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      tx_idx_q    <= '0;
      tx_id_q     <= '0;
      tx_req_q    <= 1'b0;
      done_q      <= '0;
      fail_q      <= '0;
      retry_q     <= '0;
      abort_pnd_q <= 1'b0;
    end else begin
      done_q <= '0;
      fail_q <= abort_clr;
      for (int i = 0; i < NBUF; i++) begin
        if (ld_hit[i]) begin
          slot_q[i].id   <= ld_id;
          slot_q[i].pend <= 1'b1;
        end else if (abort_clr[i]) begin
          slot_q[i].pend <= 1'b0;
        end
      end
      case (state_q)
        ST_IDLE: if ((|pend_vec) && bus_idle) state_q <= ST_SELECT;
        ST_SELECT: begin
          if (win_vld) begin
            tx_idx_q <= win_idx;
            tx_id_q  <= win_id;
            tx_req_q <= 1'b1;
            state_q  <= ST_REQ;
            if (win_idx != tx_idx_q) retry_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (sof_sent) begin
            tx_req_q    <= 1'b0;
            abort_pnd_q <= abort_req[tx_idx_q];
            state_q     <= ST_ACTIVE;
          end else if (preempt) begin
            tx_req_q <= 1'b0;
            state_q  <= ST_SELECT;
          end
        end
        ST_ACTIVE: begin
          if (abort_req[tx_idx_q]) abort_pnd_q <= 1'b1;
          if (fin_ok) begin
            done_q[tx_idx_q]      <= 1'b1;
            slot_q[tx_idx_q].pend <= 1'b0;
            retry_q               <= '0;
          end else if (fin_err) begin
            retry_q <= fin_fail ? '0 : retry_inc;
          end
          if (fin_fail) begin
            fail_q[tx_idx_q]      <= 1'b1;
            slot_q[tx_idx_q].pend <= 1'b0;
          end
          if (fin_ok || fin_err || fin_lost) begin
            abort_pnd_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_prio_id = tx_id_q;
  assign tx_idx     = tx_idx_q;
  assign pend       = pend_vec;
  assign tx_done    = done_q;
  assign tx_fail    = fail_q;
endmodule

// File: tb/tb_tx_prio_sched.sv
// Directed bench for tx_prio_sched with hand-computed expectations
// (retry limit set to 3).
module tb_tx_prio_sched;
  logic        clk = 1'b0;
  logic        g_rst;
  logic        ld_en;
  logic [1:0]  ld_idx;
  logic [10:0] ld_id;
  logic [3:0]  abort_req;
  logic        bus_idle, sof_sent, arbtr_lost, tx_lst_bit_eof, tx_err_pre;
  logic        tx_req;
  logic [10:0] tx_prio_id;
  logic [1:0]  tx_idx;
  logic [3:0]  pend, tx_done, tx_fail;

  always #5 clk = ~clk;

  tx_prio_sched #(.NBUF(4), .IDXW(2), .RETRY_MAX(3), .RCW(5)) dut (
    .clk           (clk),
    .g_rst         (g_rst),
    .ld_en         (ld_en),
    .ld_idx        (ld_idx),
    .ld_id         (ld_id),
    .abort_req     (abort_req),
    .bus_idle      (bus_idle),
    .sof_sent      (sof_sent),
    .arbtr_lost    (arbtr_lost),
    .tx_lst_bit_eof(tx_lst_bit_eof),
    .tx_err_pre    (tx_err_pre),
    .tx_req        (tx_req),
    .tx_prio_id    (tx_prio_id),
    .tx_idx        (tx_idx),
    .pend          (pend),
    .tx_done       (tx_done),
    .tx_fail       (tx_fail)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [3:0] d, input logic [3:0] f,
                        input logic [3:0] p);
    chk({tag, ".done"}, 32'(tx_done), 32'(d));
    chk({tag, ".fail"}, 32'(tx_fail), 32'(f));
    chk({tag, ".pend"}, 32'(pend), 32'(p));
  endtask

  task automatic load(input logic [1:0] idx, input logic [10:0] id);
    ld_en = 1'b1; ld_idx = idx; ld_id = id;
    step();
    ld_en = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [1:0] idx, input logic [10:0] id);
    int n = 0;
    while (!tx_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".req"}, 32'(tx_req), 32'd1);
    chk({tag, ".idx"}, 32'(tx_idx), 32'(idx));
    chk({tag, ".id"}, 32'(tx_prio_id), 32'(id));
  endtask

  task automatic sof();
    sof_sent = 1'b1; step(); sof_sent = 1'b0;
    chk("sof.req_drop", 32'(tx_req), 32'd0);
  endtask

  task automatic eof();
    tx_lst_bit_eof = 1'b1; step(); tx_lst_bit_eof = 1'b0;
  endtask

  task automatic err();
    tx_err_pre = 1'b1; step(); tx_err_pre = 1'b0;
  endtask

  task automatic lost();
    arbtr_lost = 1'b1; step(); arbtr_lost = 1'b0;
  endtask

  task automatic abort(input logic [3:0] m);
    abort_req = m; step(); abort_req = '0;
  endtask

  initial begin
    g_rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_id = '0; abort_req = '0;
    bus_idle = 1'b0; sof_sent = 1'b0; arbtr_lost = 1'b0;
    tx_lst_bit_eof = 1'b0; tx_err_pre = 1'b0;
    repeat (3) step();
    chk("rst.outs", {tx_req, tx_prio_id, tx_idx, pend, tx_done, tx_fail}, 32'd0);
    g_rst = 1'b0;
    step();

    // Basic ordering: 0x045 in slot2 beats 0x123 in slot0.
    load(2'd0, 11'h123);
    chk("ld.pend0", 32'(pend), 32'h1);
    load(2'd2, 11'h045);
    chk("ld.pend02", 32'(pend), 32'h5);
    bus_idle = 1'b1;
    step();
    chk("lat.no_req", 32'(tx_req), 32'd0);
    wait_req("b1", 2'd2, 11'h045);
    sof();
    eof();
    chk_st("b1.eof", 4'b0100, 4'b0000, 4'b0001);
    step();
    chk("b1.done_1cyc", 32'(tx_done), 32'h0);
    wait_req("b2", 2'd0, 11'h123);
    sof();
    eof();
    chk_st("b2.eof", 4'b0001, 4'b0000, 4'b0000);

    // Equal IDs: lower index first.
    bus_idle = 1'b0;
    load(2'd3, 11'h100);
    load(2'd1, 11'h100);
    bus_idle = 1'b1;
    wait_req("eq1", 2'd1, 11'h100);
    sof(); eof();
    chk_st("eq1.eof", 4'b0010, 4'b0000, 4'b1000);
    wait_req("eq3", 2'd3, 11'h100);
    sof(); eof();
    chk_st("eq3.eof", 4'b1000, 4'b0000, 4'b0000);

    // Pre-emption in REQ by a lower ID load.
    load(2'd0, 11'h200);
    wait_req("pre0", 2'd0, 11'h200);
    load(2'd3, 11'h010);
    chk("pre.req_drop", 32'(tx_req), 32'd0);
    wait_req("pre3", 2'd3, 11'h010);
    sof(); eof();
    chk_st("pre3.eof", 4'b1000, 4'b0000, 4'b0001);
    wait_req("pre0b", 2'd0, 11'h200);
    sof(); eof();
    chk_st("pre0b.eof", 4'b0001, 4'b0000, 4'b0000);

    // Slot1: err, lost, err, err -> fail on third error only.
    load(2'd1, 11'h055);
    wait_req("r1a", 2'd1, 11'h055);
    sof(); err();
    chk_st("r1.err1", 4'b0000, 4'b0000, 4'b0010);
    wait_req("r1b", 2'd1, 11'h055);
    sof(); lost();
    chk_st("r1.lost", 4'b0000, 4'b0000, 4'b0010);
    wait_req("r1c", 2'd1, 11'h055);
    sof(); err();
    chk_st("r1.err2", 4'b0000, 4'b0000, 4'b0010);
    wait_req("r1d", 2'd1, 11'h055);
    sof(); err();
    chk_st("r1.err3", 4'b0000, 4'b0010, 4'b0000);

    // Slot0: three plain errors.
    load(2'd0, 11'h0F0);
    for (int k = 0; k < 3; k++) begin
      wait_req("r0", 2'd0, 11'h0F0);
      sof(); err();
      chk_st("r0.err", 4'b0000, (k == 2) ? 4'b0001 : 4'b0000, (k == 2) ? 4'b0000 : 4'b0001);
    end

    // Abort latched during ACTIVE: success wins, error fails.
    load(2'd2, 11'h300);
    wait_req("ab1", 2'd2, 11'h300);
    sof();
    abort(4'b0100);
    chk_st("ab1.latch", 4'b0000, 4'b0000, 4'b0100);
    eof();
    chk_st("ab1.eof", 4'b0100, 4'b0000, 4'b0000);
    load(2'd2, 11'h300);
    wait_req("ab2", 2'd2, 11'h300);
    sof();
    abort(4'b0100);
    err();
    chk_st("ab2.err", 4'b0000, 4'b0100, 4'b0000);

    // Load to the active slot is ignored.
    load(2'd2, 11'h050);
    wait_req("lk", 2'd2, 11'h050);
    sof();
    load(2'd2, 11'h7FF);
    chk("lk.id", 32'(tx_prio_id), 32'h050);
    chk("lk.pend", 32'(pend), 32'h4);
    eof();
    chk_st("lk.eof", 4'b0100, 4'b0000, 4'b0000);

    // Aborts on non-active slots.
    bus_idle = 1'b0;
    step();
    load(2'd1, 11'h011);
    abort(4'b0010);
    chk_st("na.abort", 4'b0000, 4'b0010, 4'b0000);
    abort(4'b0100);
    chk_st("na.nopend", 4'b0000, 4'b0000, 4'b0000);
    ld_en = 1'b1; ld_idx = 2'd3; ld_id = 11'h022; abort_req = 4'b1000;
    step();
    ld_en = 1'b0; abort_req = '0;
    chk_st("na.ldwins", 4'b0000, 4'b0000, 4'b1000);
    abort(4'b1000);
    chk_st("na.clr3", 4'b0000, 4'b1000, 4'b0000);

    // Abort of the requested slot in REQ.
    load(2'd0, 11'h077);
    bus_idle = 1'b1;
    wait_req("rq", 2'd0, 11'h077);
    abort(4'b0001);
    chk("rq.req_drop", 32'(tx_req), 32'd0);
    chk_st("rq.abort", 4'b0000, 4'b0001, 4'b0000);
    repeat (3) step();
    chk("rq.idle", 32'(tx_req), 32'd0);

    // Asynchronous reset mid-frame.
    load(2'd1, 11'h0AA);
    wait_req("rs", 2'd1, 11'h0AA);
    sof();
    g_rst = 1'b1;
    #1;
    chk("rs.outs", {tx_req, tx_prio_id, tx_idx, pend, tx_done, tx_fail}, 32'd0);
    step();
    g_rst = 1'b0;
    step();
    chk_st("rs.after", 4'b0000, 4'b0000, 4'b0000);
    chk("rs.req", 32'(tx_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/tx_prio_sched.md
Name: tx_prio_sched

Overview:
- Transmit-side counterpart of the receive acceptance filter.
- Holds NBUF pending transmit requests, each tagged with an 11-bit priority ID, and picks the lowest ID (highest CAN priority).
- Presents the chosen ID to the bit-stream transmitter and tracks the frame to completion.
- Handles arbitration loss, error retry with a retry limit, and abort. Reports per-buffer done/fail pulses to the host side.

Parameters:
- NBUF, 4, number of transmit buffer slots (2..16).
- IDXW, 2, slot index width, equal to clog2(NBUF).
- RETRY_MAX, 16, error-retry limit per frame; 0 means unlimited retries.
- RCW, 5, retry counter width; must hold RETRY_MAX.

Ports:
- clk  in  1  clock.
- g_rst  in  1  reset, asynchronous, active-high.
- ld_en  in  1  write slot ld_idx with ld_id and set it pending.
- ld_idx  in  IDXW  slot to load.
- ld_id  in  11  priority ID for the loaded slot.
- abort_req  in  NBUF  per-slot abort request, level sampled each cycle.
- bus_idle  in  1  transmitter may start a new frame (intermission complete).
- sof_sent  in  1  pulse: transmitter has driven SOF for the requested frame.
- arbtr_lost  in  1  pulse: arbitration lost during the current frame.
- tx_lst_bit_eof  in  1  pulse: last EOF bit of the current frame transmitted.
- tx_err_pre  in  1  pulse: error detected in the current frame (bit/ack/stuff/form).
- tx_req  out  1  request to transmitter to start a frame.
- tx_prio_id  out  11  ID of the selected or active frame.
- tx_idx  out  IDXW  slot of the selected or active frame.
- pend  out  NBUF  pending flags.
- tx_done  out  NBUF  one-cycle pulse per slot: transmitted successfully.
- tx_fail  out  NBUF  one-cycle pulse per slot: aborted or retry limit reached.

Behaviour:
- Reset: all outputs are 0, state IDLE, all slot IDs 0, retry counter 0, abort latch 0.

FSM states and transitions:
- IDLE: if any pend bit is set and bus_idle=1, go to SELECT.
- SELECT (1 cycle): register the winner of the selector into tx_idx/tx_prio_id.
  - Winner is the minimum ID among pending slots; on equal IDs the lowest index wins.
  - If no slot is pending (all aborted), return to IDLE.
  - Otherwise go to REQ.
  - If the winner index differs from the previous tx_idx, clear the retry counter.
- REQ: tx_req=1, registered.
  - sof_sent: go to ACTIVE (locked), tx_req drops the next cycle.
  - Before sof_sent, if any of these occurs, drop tx_req and go to SELECT:
    - a load makes a lower ID pending;
    - a load hits the selected slot;
    - abort_req[tx_idx] is asserted.
  - The abort case clears pend[tx_idx] and pulses tx_fail.
- ACTIVE: tx_req=0, tx_idx/tx_prio_id are frozen. Events, in priority order:
  - tx_lst_bit_eof with tx_err_pre=0: pulse tx_done[tx_idx], clear pend, clear retry counter, go to IDLE. Success wins over a latched abort.
  - tx_err_pre (also when coincident with eof): increment the retry counter.
    - If it reaches RETRY_MAX (RETRY_MAX≠0), or an abort is latched: pulse tx_fail and clear pend.
    - Otherwise keep pend.
    - Go to IDLE.
  - arbtr_lost: keep pend, retry counter unchanged. If an abort is latched, clear pend and pulse tx_fail. Go to IDLE; the slot is re-arbitrated normally.
- abort_req[tx_idx] during ACTIVE is latched (abort_pnd) and acted on at the frame end. abort_req to any non-active slot clears its pend immediately and pulses tx_fail the next cycle, but only if that slot was pending.
- A load to the active slot during ACTIVE is ignored (ID and pend unchanged). Loads to other slots always take effect next cycle.
- A load coincident with abort to the same slot: the load wins (pend=1, no fail pulse).
- A load while the slot is already pending overwrites its ID and keeps pend=1.
- Latency: pend visible 1 cycle after ld_en. tx_req asserts ≥2 cycles after the first pend with bus_idle (IDLE→SELECT→REQ).
- Inputs sof_sent, arbtr_lost, tx_lst_bit_eof and tx_err_pre are ignored outside the states named above.
- Asynchronous reset mid-frame discards all slots; no done/fail pulses are generated.

Decomposition:
- Package tx_sched_pkg holds:
  - ID_W=11;
  - FSM state encoding IDLE/SELECT/REQ/ACTIVE;
  - the slot record (id, pend).
- Sub-module tx_prio_sel: combinational lowest-ID/lowest-index finder over NBUF slots, with outputs win_vld, win_idx and win_id. It is reused for the pre-emption compare in REQ.

Test Plan:
- Load slot0 ID=0x123, slot2 ID=0x045, bus_idle=1 -> tx_req with tx_prio_id=0x045, tx_idx=2; sof_sent then eof -> tx_done=4'b0100 for 1 cycle, pend=4'b0001; then slot0 is sent.
- Equal IDs 0x100 in slots 1 and 3 -> slot1 selected first.
- In REQ with slot0 ID=0x200, load slot3 ID=0x010 before sof_sent -> tx_req drops, re-asserts with ID 0x010.
- ACTIVE slot1, arbtr_lost -> no pulse, pend[1] still 1, retry counter unchanged; frame re-requested.
- RETRY_MAX=3, three tx_err_pre on slot0 -> third error gives tx_fail[0] pulse and pend[0]=0.
- abort_req[2] during ACTIVE slot2 followed by error-free eof -> tx_done[2], no tx_fail. Same abort with tx_err_pre -> tx_fail[2]. Assert g_rst mid-ACTIVE -> all outputs are 0 the same cycle.
